two_bit_mult_arb: RTL

TWO_BIT_MULT_ARB -- requirements
Module: two_bit_mult_arb

---
 rtl/two_bit_mult_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/two_bit_mult_arb.sv
// Two-requester front end for a shared 2x2-bit multiplier with a fixed latency.
// One transaction in flight; round-robin priority between requesters on contention.
//
// state | meaning
// IDLE  | arbitrate, accept one request, capture operands and grant id
// ISSUE | one-cycle start pulse to the multiplier
// WAIT  | hold operands for LAT cycles, load result on the last one
// RESP  | present product to the granted requester until it accepts
module two_bit_mult_arb #(
    parameter int LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic [1:0] resp_valid,
    input  logic [1:0] resp_ready,
    output logic [3:0] resp_data,
    output logic       mult_func,
    output logic [1:0] mult_in1,
    output logic [1:0] mult_in2,
    input  logic [3:0] mult_out,
    output logic       busy
);

    localparam logic [3:0] LAST_WAIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] a_q, a_d;
    logic [1:0] b_q, b_d;
    logic       id_q, id_d;
    logic [3:0] res_q, res_d;
    logic       gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= 2'd0;
            b_q     <= 2'd0;
            id_q    <= 1'b0;
            res_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        res_d      = res_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_data  = 4'd0;
        mult_func  = 1'b0;
        mult_in1   = 2'd0;
        mult_in2   = 2'd0;
        // Pointer only matters when both requesters compete.
        gnt        = (req_valid == 2'b11) ? ptr_q : req_valid[1];

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready = gnt ? 2'b10 : 2'b01;
                    a_d       = gnt ? req_a[3:2] : req_a[1:0];
                    b_d       = gnt ? req_b[3:2] : req_b[1:0];
                    id_d      = gnt;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mult_func = 1'b1;
                mult_in1  = a_q;
                mult_in2  = b_q;
                cnt_d     = 4'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                mult_in1 = a_q;
                mult_in2 = b_q;
                if (cnt_q == LAST_WAIT) begin
                    res_d   = mult_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                resp_valid = id_q ? 2'b10 : 2'b01;
                resp_data  = res_q;
                if (resp_ready[id_q]) begin
                    ptr_d   = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet for the whole reset interval, including the first cycle.
        if (rst) begin
            req_ready  = 2'b00;
            resp_valid = 2'b00;
            resp_data  = 4'd0;
            mult_func  = 1'b0;
            mult_in1   = 2'd0;
            mult_in2   = 2'd0;
        end
    end

    assign busy = (state_q != IDLE) && !rst;

endmodule
